// File: rtl/ps2_key_port.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered ps2_clk, frame FSM with
// watchdog, 8-bit scan-code FIFO and a registered bus status/data word.
module ps2_key_port #(
    parameter int FIFO_AW    = 3,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        GPIOd0000000_we,
    input  logic [31:0] Peripheral_in,
    output logic [31:0] xkey,
    output logic        key_ready
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] win_q, win_d;
    logic                  filt_q, filt_d;
    logic                  fall, data_s;

    state_t                state_q, state_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [7:0]            sr_q, sr_d;
    logic                  perrb_q, perrb_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  push_req, frame_err, timeout;

    logic [7:0]            mem_q [DEPTH];
    logic [FIFO_AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [FIFO_AW:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, perr_q, perr_d, terr_q, terr_d;
    logic                  full, empty, pop, do_push, do_pop, clr;
    logic [7:0]            head_d;
    logic [31:0]           xkey_q, xkey_d;
    logic                  unused_pin;

    assign unused_pin = ^Peripheral_in[31:2];
    assign data_s     = dat_sync_q[1];

    // Filtered clock only flips once the whole sample window agrees.
    always_comb begin
        win_d  = {win_q[FILTER_LEN-2:0], clk_sync_q[1]};
        filt_d = filt_q;
        fall   = 1'b0;
        if (win_q == '0) begin
            filt_d = 1'b0;
            fall   = filt_q;
        end else if (win_q == '1) begin
            filt_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sr_d      = sr_q;
        perrb_d   = perrb_q;
        push_req  = 1'b0;
        frame_err = 1'b0;
        timeout   = 1'b0;
        wd_d      = '0;
        case (state_q)
            IDLE: if (fall && !data_s) begin
                state_d  = DATA;
                bitcnt_d = 3'd0;
            end
            DATA: if (fall) begin
                sr_d     = {data_s, sr_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                perrb_d = ~(^{sr_q, data_s});
                state_d = STOP;
            end
            STOP: if (fall) begin
                push_req  = data_s && !perrb_q;
                frame_err = !data_s || perrb_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !fall) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                timeout = 1'b1;
                state_d = IDLE;
                wd_d    = '0;
            end
        end
    end

    // Pop and full-ness are judged on the pre-cycle FIFO state.
    always_comb begin
        full    = (cnt_q == (FIFO_AW+1)'(DEPTH));
        empty   = (cnt_q == '0);
        clr     = GPIOd0000000_we && Peripheral_in[1];
        pop     = GPIOd0000000_we && Peripheral_in[0];
        do_pop  = pop && !empty;
        do_push = push_req && (!full || do_pop);
        wp_d    = do_push ? wp_q + 1'b1 : wp_q;
        rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
        ovf_d   = (push_req && !do_push) || (ovf_q && !clr);
        perr_d  = frame_err || (perr_q && !clr);
        terr_d  = timeout || (terr_q && !clr);
        if (cnt_d == '0) head_d = 8'h00;
        else if (do_push && wp_q == rp_d) head_d = sr_q;
        else head_d = mem_q[rp_d];
        xkey_d  = {cnt_d != '0, ovf_d, perr_d, terr_d, 4'h0, 8'(cnt_d), 8'h00, head_d};
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= sr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            win_q      <= '1;
            filt_q     <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            sr_q       <= 8'h00;
            perrb_q    <= 1'b0;
            wd_q       <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            terr_q     <= 1'b0;
            xkey_q     <= 32'h0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            win_q      <= win_d;
            filt_q     <= filt_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            sr_q       <= sr_d;
            perrb_q    <= perrb_d;
            wd_q       <= wd_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            terr_q     <= terr_d;
            xkey_q     <= xkey_d;
        end
    end

    assign xkey      = xkey_q;
    assign key_ready = xkey_q[31];
endmodule
